// File: rtl/cc_gen_if.sv
// Condition-code generator bus: EX-stage flag inputs, pipeline controls,
// direct CCR write port, and the forwarded/committed flag outputs.
interface cc_gen_if #(
    parameter int WIDTH = 32
);
    logic             ex_valid;
    logic             ex_setcc;
    logic [1:0]       ex_op;
    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_b;
    logic [WIDTH-1:0] ex_res;
    logic             stall;
    logic             flush;
    logic             ccr_wr_en;
    logic [3:0]       ccr_wr_data;
    logic [3:0]       cc4;
    logic [3:0]       ccr_q;
    logic             cc_pending;

    modport master (
        output ex_valid, ex_setcc, ex_op, ex_a, ex_b, ex_res,
        output stall, flush, ccr_wr_en, ccr_wr_data,
        input  cc4, ccr_q, cc_pending
    );

    modport slave (
        input  ex_valid, ex_setcc, ex_op, ex_a, ex_b, ex_res,
        input  stall, flush, ccr_wr_en, ccr_wr_data,
        output cc4, ccr_q, cc_pending
    );
endinterface

// File: rtl/cc_gen_unit.sv
// Condition-code generator: computes ZNCV in EX, carries them through M/W,
// commits to the CCR, and forwards the youngest in-flight flags to branches.
module cc_gen_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    cc_gen_if.slave  bus
);
    localparam int S = WIDTH - 1;

    typedef enum logic [1:0] {
        OP_LOGIC = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_PASS  = 2'b11
    } cc_op_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] flags;  // {v, c, n, z}
    } cc_entry_t;

    cc_entry_t  m_q, m_d, w_q, w_d;
    logic [3:0] ccr_q, ccr_d;
    logic [3:0] ex_flags;
    logic [3:0] cc4;
    logic       a_s, b_s, r_s;

    assign a_s = bus.ex_a[S];
    assign b_s = bus.ex_b[S];
    assign r_s = bus.ex_res[S];

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ex_flags    = 4'b0000;
        ex_flags[0] = (bus.ex_res == '0);
        ex_flags[1] = r_s;
        unique case (cc_op_e'(bus.ex_op))
            OP_ADD: begin
                ex_flags[2] = (a_s & b_s) | ((a_s | b_s) & ~r_s);
                ex_flags[3] = (a_s == b_s) & (r_s != a_s);
            end
            OP_SUB: begin
                ex_flags[2] = (a_s & ~b_s) | ((a_s | ~b_s) & ~r_s);
                ex_flags[3] = (a_s != b_s) & (r_s != a_s);
            end
            // Pass keeps whatever C/V a branch would see right now.
            OP_PASS: ex_flags[3:2] = cc4[3:2];
            default: ex_flags[3:2] = 2'b00;
        endcase
    end

    always_comb begin
        if (m_q.valid)      cc4 = m_q.flags;
        else if (w_q.valid) cc4 = w_q.flags;
        else                cc4 = ccr_q;
    end

    always_comb begin
        m_d   = m_q;
        w_d   = w_q;
        ccr_d = ccr_q;
        if (bus.ccr_wr_en) begin
            // Context restore overrides the pipeline and drops any W commit.
            ccr_d     = bus.ccr_wr_data;
            m_d.valid = 1'b0;
            w_d.valid = 1'b0;
        end else if (bus.stall) begin
            if (bus.flush) begin
                m_d.valid = 1'b0;
                w_d.valid = 1'b0;
            end
        end else begin
            m_d.valid = bus.ex_valid & bus.ex_setcc & ~bus.flush;
            m_d.flags = ex_flags;
            w_d.valid = m_q.valid & ~bus.flush;
            w_d.flags = m_q.flags;
            if (w_q.valid) ccr_d = w_q.flags;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them sample the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q   <= '0;
            w_q   <= '0;
            ccr_q <= 4'b0000;
        end else begin
            m_q   <= m_d;
            w_q   <= w_d;
            ccr_q <= ccr_d;
        end
    end

    assign bus.cc4        = cc4;
    assign bus.ccr_q      = ccr_q;
    assign bus.cc_pending = m_q.valid | w_q.valid;
endmodule

// File: tb/tb_cc_gen_unit.sv
// Directed bench for cc_gen_unit: flag math, pipeline latency, forwarding,
// flush/stall, CCR write and reset, with hand-computed expected flags.
module tb_cc_gen_unit;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    cc_gen_if #(.WIDTH(32)) bus ();

    cc_gen_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ex_valid    = 1'b0;
        bus.ex_setcc    = 1'b0;
        bus.ex_op       = 2'b00;
        bus.ex_a        = '0;
        bus.ex_b        = '0;
        bus.ex_res      = '0;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.ccr_wr_en   = 1'b0;
        bus.ccr_wr_data = 4'b0000;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res);
        bus.ex_valid = 1'b1;
        bus.ex_setcc = 1'b1;
        bus.ex_op    = op;
        bus.ex_a     = a;
        bus.ex_b     = b;
        bus.ex_res   = res;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (bus.cc4 !== 4'b0000) begin bad++; $display("FAIL reset_cc4 got=%b exp=%b", bus.cc4, 4'b0000); end
        total++; if (bus.ccr_q !== 4'b0000) begin bad++; $display("FAIL reset_ccr got=%b exp=%b", bus.ccr_q, 4'b0000); end
        total++; if (bus.cc_pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b exp=0", bus.cc_pending); end
    endtask

    task automatic test_add_overflow();
        issue(2'b01, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
        tick();
        idle();
        total++; if (bus.cc4 !== 4'b1010) begin bad++; $display("FAIL add_cc4_m got=%b exp=%b", bus.cc4, 4'b1010); end
        total++; if (bus.cc_pending !== 1'b1) begin bad++; $display("FAIL add_pending1 got=%b exp=1", bus.cc_pending); end
        total++; if (bus.ccr_q !== 4'b0000) begin bad++; $display("FAIL add_ccr_early1 got=%b exp=%b", bus.ccr_q, 4'b0000); end
        tick();
        total++; if (bus.cc4 !== 4'b1010) begin bad++; $display("FAIL add_cc4_w got=%b exp=%b", bus.cc4, 4'b1010); end
        total++; if (bus.cc_pending !== 1'b1) begin bad++; $display("FAIL add_pending2 got=%b exp=1", bus.cc_pending); end
        total++; if (bus.ccr_q !== 4'b0000) begin bad++; $display("FAIL add_ccr_early2 got=%b exp=%b", bus.ccr_q, 4'b0000); end
        tick();
        total++; if (bus.ccr_q !== 4'b1010) begin bad++; $display("FAIL add_ccr_commit got=%b exp=%b", bus.ccr_q, 4'b1010); end
        total++; if (bus.cc_pending !== 1'b0) begin bad++; $display("FAIL add_pending3 got=%b exp=0", bus.cc_pending); end
    endtask

    task automatic test_sub();
        issue(2'b10, 32'd5, 32'd5, 32'd0);
        tick();
        total++; if (bus.cc4 !== 4'b0101) begin bad++; $display("FAIL sub_eq_cc4 got=%b exp=%b", bus.cc4, 4'b0101); end
        issue(2'b10, 32'd3, 32'd5, 32'hFFFF_FFFE);
        tick();
        idle();
        total++; if (bus.cc4 !== 4'b0010) begin bad++; $display("FAIL sub_lt_cc4 got=%b exp=%b", bus.cc4, 4'b0010); end
        tick();
        tick();
        total++; if (bus.ccr_q !== 4'b0010) begin bad++; $display("FAIL sub_ccr got=%b exp=%b", bus.ccr_q, 4'b0010); end
    endtask

    task automatic test_back_to_back();
        issue(2'b10, 32'd3, 32'd5, 32'hFFFF_FFFE);
        tick();
        total++; if (bus.cc4 !== 4'b0010) begin bad++; $display("FAIL b2b_first got=%b exp=%b", bus.cc4, 4'b0010); end
        issue(2'b01, 32'hFFFF_FFFF, 32'h1, 32'h0);
        tick();
        idle();
        total++; if (bus.cc4 !== 4'b0101) begin bad++; $display("FAIL b2b_second got=%b exp=%b", bus.cc4, 4'b0101); end
        tick();
        total++; if (bus.ccr_q !== 4'b0010) begin bad++; $display("FAIL b2b_ccr_mid got=%b exp=%b", bus.ccr_q, 4'b0010); end
        tick();
        total++; if (bus.ccr_q !== 4'b0101) begin bad++; $display("FAIL b2b_ccr_end got=%b exp=%b", bus.ccr_q, 4'b0101); end
    endtask

    task automatic test_pass_logic();
        bus.ccr_wr_en   = 1'b1;
        bus.ccr_wr_data = 4'b1100;
        tick();
        idle();
        total++; if (bus.ccr_q !== 4'b1100) begin bad++; $display("FAIL wr_ccr got=%b exp=%b", bus.ccr_q, 4'b1100); end
        issue(2'b11, 32'd0, 32'd0, 32'd0);
        tick();
        total++; if (bus.cc4 !== 4'b1101) begin bad++; $display("FAIL pass_cc4 got=%b exp=%b", bus.cc4, 4'b1101); end
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000);
        tick();
        idle();
        total++; if (bus.cc4 !== 4'b0010) begin bad++; $display("FAIL logic_cc4 got=%b exp=%b", bus.cc4, 4'b0010); end
        tick();
        tick();
        total++; if (bus.ccr_q !== 4'b0010) begin bad++; $display("FAIL logic_ccr got=%b exp=%b", bus.ccr_q, 4'b0010); end
    endtask

    task automatic test_flush_stall();
        issue(2'b00, 32'd0, 32'd0, 32'd0);
        tick();
        total++; if (bus.cc4 !== 4'b0001) begin bad++; $display("FAIL fl_setup got=%b exp=%b", bus.cc4, 4'b0001); end
        // EX still valid during the flush: it must die too.
        issue(2'b01, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
        bus.flush = 1'b1;
        tick();
        idle();
        total++; if (bus.cc_pending !== 1'b0) begin bad++; $display("FAIL fl_pending got=%b exp=0", bus.cc_pending); end
        total++; if (bus.ccr_q !== 4'b0010) begin bad++; $display("FAIL fl_ccr got=%b exp=%b", bus.ccr_q, 4'b0010); end
        total++; if (bus.cc4 !== 4'b0010) begin bad++; $display("FAIL fl_cc4 got=%b exp=%b", bus.cc4, 4'b0010); end
        tick();
        total++; if (bus.ccr_q !== 4'b0010) begin bad++; $display("FAIL fl_nocommit got=%b exp=%b", bus.ccr_q, 4'b0010); end

        issue(2'b01, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
        tick();
        issue(2'b10, 32'd5, 32'd5, 32'd0);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.cc4 !== 4'b1010) begin bad++; $display("FAIL st_cc4[%0d] got=%b exp=%b", i, bus.cc4, 4'b1010); end
            total++; if (bus.ccr_q !== 4'b0010) begin bad++; $display("FAIL st_ccr[%0d] got=%b exp=%b", i, bus.ccr_q, 4'b0010); end
            total++; if (bus.cc_pending !== 1'b1) begin bad++; $display("FAIL st_pending[%0d] got=%b exp=1", i, bus.cc_pending); end
        end
        bus.flush = 1'b1;
        tick();
        idle();
        total++; if (bus.cc_pending !== 1'b0) begin bad++; $display("FAIL stfl_pending got=%b exp=0", bus.cc_pending); end
        total++; if (bus.cc4 !== 4'b0010) begin bad++; $display("FAIL stfl_cc4 got=%b exp=%b", bus.cc4, 4'b0010); end
        tick();
        tick();
        total++; if (bus.ccr_q !== 4'b0010) begin bad++; $display("FAIL stfl_ccr got=%b exp=%b", bus.ccr_q, 4'b0010); end
    endtask

    task automatic test_ccr_write_reset();
        // 0xFFFFFFFF + 2 = 1: carry only -> 4'b0100.
        issue(2'b01, 32'hFFFF_FFFF, 32'h2, 32'h1);
        tick();
        idle();
        tick();
        total++; if (bus.cc4 !== 4'b0100) begin bad++; $display("FAIL wrw_setup got=%b exp=%b", bus.cc4, 4'b0100); end
        bus.ccr_wr_en   = 1'b1;
        bus.ccr_wr_data = 4'b1000;
        tick();
        idle();
        total++; if (bus.ccr_q !== 4'b1000) begin bad++; $display("FAIL wrw_ccr got=%b exp=%b", bus.ccr_q, 4'b1000); end
        total++; if (bus.cc_pending !== 1'b0) begin bad++; $display("FAIL wrw_pending got=%b exp=0", bus.cc_pending); end
        tick();
        total++; if (bus.ccr_q !== 4'b1000) begin bad++; $display("FAIL wrw_hold got=%b exp=%b", bus.ccr_q, 4'b1000); end

        issue(2'b01, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
        tick();
        bus.ccr_wr_en   = 1'b1;
        bus.ccr_wr_data = 4'b1111;
        bus.stall       = 1'b1;
        rst             = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        total++; if (bus.cc4 !== 4'b0000) begin bad++; $display("FAIL rst_cc4 got=%b exp=%b", bus.cc4, 4'b0000); end
        total++; if (bus.ccr_q !== 4'b0000) begin bad++; $display("FAIL rst_ccr got=%b exp=%b", bus.ccr_q, 4'b0000); end
        total++; if (bus.cc_pending !== 1'b0) begin bad++; $display("FAIL rst_pending got=%b exp=0", bus.cc_pending); end
        tick();
        tick();
        total++; if (bus.ccr_q !== 4'b0000) begin bad++; $display("FAIL rst_after got=%b exp=%b", bus.ccr_q, 4'b0000); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        test_reset();
        test_add_overflow();
        test_sub();
        test_back_to_back();
        test_pass_logic();
        test_flush_stall();
        test_ccr_write_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
